scalar_inst_decode: RTL and testbench

- Decode stage that sits directly upstream of the scalar ALU and branch unit.
- Takes the fetched 32-bit instruction dword stream and classifies each instruction as SOP2, SOP1, SOPK, SOPC or SOPP.
- Extracts opcode and operand fields, and collects an optional trailing 32-bit literal dword.
- Issues one decoded scalar op per instruction through a single-entry registered output with valid/ready.

---
 rtl/scalar_op_pkg.sv | 59 +++++
 rtl/scalar_fmt_classify.sv | 75 +++++++
 rtl/scalar_inst_decode.sv | 135 +++++++++++++
 tb/tb_scalar_inst_decode.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/scalar_op_pkg.sv
// scalar_op_pkg
// Shared definitions for the scalar decode slice: instruction format enum,
// encoding-prefix constants, opcode constants, literal-source encoding,
// decoded-field struct and opcode-legality helper.
// Optional feature macro consumed by users of this package:
// SCALAR_DEC_OPCHECK_EN (flags undefined opcodes as illegal).
package scalar_op_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_SOP2 = 3'd1,
        FMT_SOP1 = 3'd2,
        FMT_SOPK = 3'd3,
        FMT_SOPC = 3'd4,
        FMT_SOPP = 3'd5
    } fmt_e;

    // Encoding prefixes, checked in this order (first match wins)
    localparam logic [8:0] PFX_SOPP = 9'h17F;
    localparam logic [8:0] PFX_SOPC = 9'h17E;
    localparam logic [8:0] PFX_SOP1 = 9'h17D;
    localparam logic [3:0] PFX_SOPK = 4'hB;
    localparam logic [1:0] PFX_SOP2 = 2'b10;

    // Source-operand encoding meaning "a 32-bit literal dword follows"
    localparam logic [7:0] LIT_SRC_DEFAULT = 8'd255;

    // SOPK opcode whose immediate is carried in a trailing literal dword
    localparam logic [4:0] SOPK_SETREG_IMM32_B32 = 5'd21;

    typedef struct packed {
        fmt_e        fmt;
        logic [7:0]  op;
        logic [6:0]  sdst;
        logic [7:0]  ssrc0;
        logic [7:0]  ssrc1;
        logic [15:0] simm16;
        logic        illegal;
    } dec_fields_t;

    // Returns 1 when op is a defined opcode for the given format
    function automatic logic op_defined(input fmt_e fmt, input logic [7:0] op);
        logic ok;
        case (fmt)
            FMT_SOP2: ok = !((op == 8'd12) || (op == 8'd13) || (op == 8'd43) ||
                             (op == 8'd45) || (op > 8'd54));
            FMT_SOP1: ok = !((op < 8'd3) || (op == 8'd35) || (op == 8'd50) ||
                             (op == 8'd51) || (op == 8'd53) || (op == 8'd54) ||
                             (op == 8'd72) || (op > 8'd73));
            FMT_SOPK: ok = !((op == 8'd17) || (op == 8'd20) || (op > 8'd28));
            FMT_SOPC: ok = !((op == 8'd16) || (op == 8'd17) || (op > 8'd19));
            FMT_SOPP: ok = !((op == 8'd28) || (op == 8'd29) || (op == 8'd34) ||
                             (op == 8'd38) || (op == 8'd39) || (op > 8'd40));
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/scalar_fmt_classify.sv
// scalar_fmt_classify
// Purely combinational classifier for one scalar instruction dword.
// Ports:
//   dword     in  32  instruction dword
//   fields    out     decoded format, opcode, operands, immediate, illegal
//   needs_lit out 1   a literal dword must follow this instruction
// Config macro: SCALAR_DEC_OPCHECK_EN - also flag undefined opcodes illegal.
module scalar_fmt_classify
    import scalar_op_pkg::*;
#(
    parameter logic [7:0] LIT_SRC = LIT_SRC_DEFAULT
) (
    input  logic [31:0] dword,
    output dec_fields_t fields,
    output logic        needs_lit
);

    dec_fields_t fields_s;
    logic        needs_lit_s;

    // Format match, field extraction, legality and literal requirement
    always_comb begin
        fields_s    = '0;
        needs_lit_s = 1'b0;
        if (dword[31:23] == PFX_SOPP) begin
            fields_s.fmt    = FMT_SOPP;
            fields_s.op     = {1'b0, dword[22:16]};
            fields_s.simm16 = dword[15:0];
        end else if (dword[31:23] == PFX_SOPC) begin
            fields_s.fmt   = FMT_SOPC;
            fields_s.op    = {1'b0, dword[22:16]};
            fields_s.ssrc1 = dword[15:8];
            fields_s.ssrc0 = dword[7:0];
        end else if (dword[31:23] == PFX_SOP1) begin
            fields_s.fmt   = FMT_SOP1;
            fields_s.sdst  = dword[22:16];
            fields_s.op    = dword[15:8];
            fields_s.ssrc0 = dword[7:0];
        end else if (dword[31:28] == PFX_SOPK) begin
            fields_s.fmt    = FMT_SOPK;
            fields_s.op     = {3'b000, dword[27:23]};
            fields_s.sdst   = dword[22:16];
            fields_s.simm16 = dword[15:0];
        end else if (dword[31:30] == PFX_SOP2) begin
            fields_s.fmt   = FMT_SOP2;
            fields_s.op    = {1'b0, dword[29:23]};
            fields_s.sdst  = dword[22:16];
            fields_s.ssrc1 = dword[15:8];
            fields_s.ssrc0 = dword[7:0];
        end else begin
            fields_s.fmt = FMT_NONE;
        end

`ifdef SCALAR_DEC_OPCHECK_EN
        fields_s.illegal = (fields_s.fmt == FMT_NONE) || !op_defined(fields_s.fmt, fields_s.op);
`else
        fields_s.illegal = (fields_s.fmt == FMT_NONE);
`endif

        case (fields_s.fmt)
            FMT_SOP2, FMT_SOPC:
                needs_lit_s = (fields_s.ssrc0 == LIT_SRC) || (fields_s.ssrc1 == LIT_SRC);
            FMT_SOP1:
                needs_lit_s = (fields_s.ssrc0 == LIT_SRC);
            FMT_SOPK:
                needs_lit_s = (fields_s.op == {3'b000, SOPK_SETREG_IMM32_B32});
            default:
                needs_lit_s = 1'b0;
        endcase
    end

    assign fields    = fields_s;
    assign needs_lit = needs_lit_s;

endmodule

// File: rtl/scalar_inst_decode.sv
// scalar_inst_decode
// Scalar decode stage: classifies each incoming instruction dword, gathers
// an optional trailing literal dword and issues one decoded op through a
// single-entry registered output with valid/ready.
// Ports:
//   clk, rst (sync, active high), flush
//   in_valid/in_ready/in_dword/in_pc      instruction dword stream
//   out_valid/out_ready                   decoded op handshake
//   out_fmt, out_op, out_sdst, out_ssrc0, out_ssrc1, out_simm16,
//   out_literal, out_has_lit, out_illegal, out_pc   decoded op fields
// Config macro: SCALAR_DEC_OPCHECK_EN - undefined opcodes raise out_illegal.
module scalar_inst_decode
    import scalar_op_pkg::*;
#(
    parameter int         PC_WIDTH = 48,
    parameter logic [7:0] LIT_SRC  = LIT_SRC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_dword,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          out_fmt,
    output logic [7:0]          out_op,
    output logic [6:0]          out_sdst,
    output logic [7:0]          out_ssrc0,
    output logic [7:0]          out_ssrc1,
    output logic [15:0]         out_simm16,
    output logic [31:0]         out_literal,
    output logic                out_has_lit,
    output logic                out_illegal,
    output logic [PC_WIDTH-1:0] out_pc
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LIT  = 1'b1
    } state_e;

    state_e                state_r;
    dec_fields_t           cls_fields_s;
    logic                  cls_needs_lit_s;
    dec_fields_t           hold_r;
    logic [PC_WIDTH-1:0]   hold_pc_r;
    dec_fields_t           out_r;
    logic [31:0]           out_lit_r;
    logic                  out_has_lit_r;
    logic [PC_WIDTH-1:0]   out_pc_r;
    logic                  out_valid_r;
    logic                  in_ready_s;
    logic                  accept_s;

    scalar_fmt_classify #(
        .LIT_SRC (LIT_SRC)
    ) u_classify (
        .dword     (in_dword),
        .fields    (cls_fields_s),
        .needs_lit (cls_needs_lit_s)
    );

    // Accept only when the output slot is free or drains this same edge
    always_comb begin
        in_ready_s = !flush && (!out_valid_r || out_ready);
        accept_s   = in_valid && in_ready_s;
    end

    // Decode FSM, literal hold register and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            hold_r        <= '0;
            hold_pc_r     <= '0;
            out_r         <= '0;
            out_lit_r     <= 32'd0;
            out_has_lit_r <= 1'b0;
            out_pc_r      <= '0;
            out_valid_r   <= 1'b0;
        end else if (flush) begin
            // Partial instruction is dropped simply by returning to IDLE
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
        end else begin
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (accept_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (cls_needs_lit_s) begin
                            hold_r    <= cls_fields_s;
                            hold_pc_r <= in_pc;
                            state_r   <= ST_LIT;
                        end else begin
                            out_r         <= cls_fields_s;
                            out_lit_r     <= 32'd0;
                            out_has_lit_r <= 1'b0;
                            out_pc_r      <= in_pc;
                            out_valid_r   <= 1'b1;
                        end
                    end
                    ST_LIT: begin
                        // This dword is data only; never classified
                        out_r         <= hold_r;
                        out_lit_r     <= in_dword;
                        out_has_lit_r <= 1'b1;
                        out_pc_r      <= hold_pc_r;
                        out_valid_r   <= 1'b1;
                        state_r       <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_fmt     = out_r.fmt;
    assign out_op      = out_r.op;
    assign out_sdst    = out_r.sdst;
    assign out_ssrc0   = out_r.ssrc0;
    assign out_ssrc1   = out_r.ssrc1;
    assign out_simm16  = out_r.simm16;
    assign out_illegal = out_r.illegal;
    assign out_literal = out_lit_r;
    assign out_has_lit = out_has_lit_r;
    assign out_pc      = out_pc_r;

endmodule

// File: tb/tb_scalar_inst_decode.sv
// tb_scalar_inst_decode
// Directed self-checking bench for scalar_inst_decode with hand-computed
// expected values. Inputs change and outputs are sampled 1ns after posedge.
module tb_scalar_inst_decode;

    localparam int PCW = 48;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_dword;
    logic [PCW-1:0] in_pc;
    logic           out_valid;
    logic           out_ready;
    logic [2:0]     out_fmt;
    logic [7:0]     out_op;
    logic [6:0]     out_sdst;
    logic [7:0]     out_ssrc0;
    logic [7:0]     out_ssrc1;
    logic [15:0]    out_simm16;
    logic [31:0]    out_literal;
    logic           out_has_lit;
    logic           out_illegal;
    logic [PCW-1:0] out_pc;

    int n_checks;
    int n_pass;

    scalar_inst_decode #(
        .PC_WIDTH (PCW),
        .LIT_SRC  (8'd255)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dword    (in_dword),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_fmt     (out_fmt),
        .out_op      (out_op),
        .out_sdst    (out_sdst),
        .out_ssrc0   (out_ssrc0),
        .out_ssrc1   (out_ssrc1),
        .out_simm16  (out_simm16),
        .out_literal (out_literal),
        .out_has_lit (out_has_lit),
        .out_illegal (out_illegal),
        .out_pc      (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one dword, wait (bounded) for acceptance, then drop in_valid
    task automatic send(input logic [31:0] d, input logic [PCW-1:0] pc);
        int waited;
        in_valid = 1'b1;
        in_dword = d;
        in_pc    = pc;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("accept_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_dword  = 32'd0;
        in_pc     = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_fmt", 64'(out_fmt), 64'd0);
        check("rst_op", 64'(out_op), 64'd0);
        check("rst_lit", 64'(out_literal), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);

        // SOP2 single dword
        send(32'h8003_0201, 48'h100);
        check("sop2_valid", 64'(out_valid), 64'd1);
        check("sop2_fmt", 64'(out_fmt), 64'd1);
        check("sop2_op", 64'(out_op), 64'd0);
        check("sop2_sdst", 64'(out_sdst), 64'd3);
        check("sop2_ssrc0", 64'(out_ssrc0), 64'd1);
        check("sop2_ssrc1", 64'(out_ssrc1), 64'd2);
        check("sop2_haslit", 64'(out_has_lit), 64'd0);
        check("sop2_illegal", 64'(out_illegal), 64'd0);
        check("sop2_pc", 64'(out_pc), 64'h100);

        // SOP1 with literal
        send(32'hBE85_03FF, 48'h200);
        check("sop1_nolit_yet", 64'(out_valid), 64'd0);
        send(32'hDEAD_BEEF, 48'h204);
        check("sop1_valid", 64'(out_valid), 64'd1);
        check("sop1_fmt", 64'(out_fmt), 64'd2);
        check("sop1_op", 64'(out_op), 64'd3);
        check("sop1_sdst", 64'(out_sdst), 64'd5);
        check("sop1_ssrc0", 64'(out_ssrc0), 64'd255);
        check("sop1_lit", 64'(out_literal), 64'hDEAD_BEEF);
        check("sop1_haslit", 64'(out_has_lit), 64'd1);
        check("sop1_pc", 64'(out_pc), 64'h200);
        tick();
        check("sop1_single_op", 64'(out_valid), 64'd0);

        // Backpressure hold, then replace-on-handshake throughput
        out_ready = 1'b0;
        send(32'hBF81_0000, 48'h300);
        in_valid = 1'b1;
        in_dword = 32'hBF82_0000;
        in_pc    = 48'h304;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_fmt", 64'(out_fmt), 64'd5);
            check("bp_op", 64'(out_op), 64'd1);
            check("bp_pc", 64'(out_pc), 64'h300);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("tp1_valid", 64'(out_valid), 64'd1);
        check("tp1_op", 64'(out_op), 64'd2);
        check("tp1_pc", 64'(out_pc), 64'h304);
        in_dword = 32'hBF83_0000;
        in_pc    = 48'h308;
        tick();
        check("tp2_valid", 64'(out_valid), 64'd1);
        check("tp2_op", 64'(out_op), 64'd3);
        in_valid = 1'b0;
        tick();
        check("tp_drain", 64'(out_valid), 64'd0);

        // Flush discards a half-received instruction
        send(32'hBE85_03FF, 48'h400);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_dword = 32'hDEAD_BEEF;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        send(32'hBF81_0000, 48'h404);
        check("postflush_fmt", 64'(out_fmt), 64'd5);
        check("postflush_op", 64'(out_op), 64'd1);
        check("postflush_haslit", 64'(out_has_lit), 64'd0);
        check("postflush_pc", 64'(out_pc), 64'h404);

        // Non-scalar encoding: illegal, no literal consumed
        send(32'h7E00_0280, 48'h500);
        check("none_valid", 64'(out_valid), 64'd1);
        check("none_fmt", 64'(out_fmt), 64'd0);
        check("none_illegal", 64'(out_illegal), 64'd1);
        check("none_haslit", 64'(out_has_lit), 64'd0);
        send(32'hBF81_0000, 48'h504);
        check("after_none_fmt", 64'(out_fmt), 64'd5);

        // SOP2 op 12: undefined opcode
        send(32'h8600_0000, 48'h600);
        check("op12_fmt", 64'(out_fmt), 64'd1);
        check("op12_op", 64'(out_op), 64'd12);
`ifdef SCALAR_DEC_OPCHECK_EN
        check("op12_illegal", 64'(out_illegal), 64'd1);
`else
        check("op12_illegal", 64'(out_illegal), 64'd0);
`endif

        // SOPK setreg_imm32 takes a literal
        send(32'hBA80_0001, 48'h700);
        check("sopk_wait", 64'(out_valid), 64'd0);
        send(32'h1234_5678, 48'h704);
        check("sopk_fmt", 64'(out_fmt), 64'd3);
        check("sopk_op", 64'(out_op), 64'd21);
        check("sopk_simm", 64'(out_simm16), 64'd1);
        check("sopk_lit", 64'(out_literal), 64'h1234_5678);
        check("sopk_pc", 64'(out_pc), 64'h700);

        // SOPC with literal on ssrc1
        send(32'hBF00_FF05, 48'h800);
        check("sopc_wait", 64'(out_valid), 64'd0);
        send(32'hCAFE_F00D, 48'h804);
        check("sopc_fmt", 64'(out_fmt), 64'd4);
        check("sopc_ssrc1", 64'(out_ssrc1), 64'd255);
        check("sopc_ssrc0", 64'(out_ssrc0), 64'd5);
        check("sopc_sdst", 64'(out_sdst), 64'd0);
        check("sopc_lit", 64'(out_literal), 64'hCAFE_F00D);
        check("sopc_haslit", 64'(out_has_lit), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
